// File: rtl/mem_wr_sched_if.sv
// Bus bundle for the store scheduler: two requester ports, the memory write
// channel and the status outputs. The slave modport is the scheduler's view.
interface mem_wr_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [1:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [1:0]  req1_op;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;

    logic        err_align;
    logic        err_src;
    logic        busy;

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_op,
        input  req1_valid, req1_addr, req1_wdata, req1_op,
        input  mem_ready,
        output req0_ready, req1_ready,
        output mem_valid, mem_addr, mem_byteen, mem_wdata,
        output err_align, err_src, busy
    );

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_op,
        output req1_valid, req1_addr, req1_wdata, req1_op,
        output mem_ready,
        input  req0_ready, req1_ready,
        input  mem_valid, mem_addr, mem_byteen, mem_wdata,
        input  err_align, err_src, busy
    );
endinterface

// File: rtl/mem_wr_sched.sv
// Two-requester store scheduler: round-robin arbitration, alignment check,
// lane formatting at accept time, and a FIFO feeding one write beat per cycle.
module mem_wr_sched #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_wr_sched_if.slave  bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             rr_q;          // 1: requester 1 wins a tie
    logic             err_align_q, err_src_q;

    logic [31:0] addr_mem  [FIFO_DEPTH];
    logic [3:0]  be_mem    [FIFO_DEPTH];
    logic [31:0] wdata_mem [FIFO_DEPTH];

    logic        gnt, gnt_sel;
    logic [31:0] sel_addr, sel_data;
    logic [1:0]  sel_op;
    logic        misalign, enq, deq;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;

    // Arbitration: tie resolved by rr_q, no grant while the FIFO is full.
    always_comb begin
        gnt_sel  = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
        gnt      = (bus.req0_valid || bus.req1_valid) && (count_q < DEPTH_C);
        sel_addr = gnt_sel ? bus.req1_addr  : bus.req0_addr;
        sel_data = gnt_sel ? bus.req1_wdata : bus.req0_wdata;
        sel_op   = gnt_sel ? bus.req1_op    : bus.req0_op;
    end

    assign bus.req0_ready = gnt && !gnt_sel;
    assign bus.req1_ready = gnt && gnt_sel;

    // Alignment check and byte-lane formatting of the selected request.
    always_comb begin
        misalign  = 1'b0;
        fmt_be    = '0;
        fmt_wdata = '0;
        unique case (sel_op)
            2'b01: begin
                if (sel_addr[1:0] != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    fmt_be    = 4'b1111;
                    fmt_wdata = sel_data;
                end
            end
            2'b10: begin
                if (sel_addr[0]) begin
                    misalign = 1'b1;
                end else if (sel_addr[1]) begin
                    fmt_be    = 4'b1100;
                    fmt_wdata = {sel_data[15:0], 16'b0};
                end else begin
                    fmt_be    = 4'b0011;
                    fmt_wdata = {16'b0, sel_data[15:0]};
                end
            end
            2'b11: begin
                fmt_be    = 4'b0001 << sel_addr[1:0];
                fmt_wdata = {24'b0, sel_data[7:0]} << {sel_addr[1:0], 3'b000};
            end
            default: ;
        endcase
    end

    assign enq = gnt && (sel_op != 2'b00) && !misalign;
    assign deq = (state_q == ISSUE) && bus.mem_ready;

    // Next state, occupancy and memory-side outputs.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        bus.mem_valid  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_byteen = '0;
        bus.mem_wdata  = '0;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: ;
        endcase
        unique case (state_q)
            IDLE: begin
                if (enq) state_d = ISSUE;
            end
            ISSUE: begin
                bus.mem_valid  = 1'b1;
                bus.mem_addr   = addr_mem[rd_ptr_q];
                bus.mem_byteen = be_mem[rd_ptr_q];
                bus.mem_wdata  = wdata_mem[rd_ptr_q];
                if (deq && !enq && (count_q == ONE_C)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: pointers, FSM, arbitration pointer and error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rr_q        <= 1'b0;
            err_align_q <= 1'b0;
            err_src_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            err_align_q <= gnt && misalign;
            if (enq)             wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
            if (deq)             rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
            if (gnt)             rr_q      <= ~gnt_sel;
            if (gnt && misalign) err_src_q <= gnt_sel;
        end
    end

    // Entry storage; contents are only visible through mem_* while ISSUE.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr_q]  <= {sel_addr[31:2], 2'b00};
            be_mem[wr_ptr_q]    <= fmt_be;
            wdata_mem[wr_ptr_q] <= fmt_wdata;
        end
    end

    assign bus.err_align = err_align_q;
    assign bus.err_src   = err_src_q;
    assign bus.busy      = (count_q != '0);
endmodule

// File: tb/tb_mem_wr_sched.sv
// Directed plus randomized bench for mem_wr_sched against a queue-based model.
module tb_mem_wr_sched;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_wr_sched_if bus();

    mem_wr_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } beat_t;

    beat_t q[$];
    int    favour;
    logic  m_err, m_errsrc;
    int    vectors = 0;
    int    miscompares = 0;

    logic        o_r0, o_r1, o_mv, o_err, o_src, o_busy;
    logic [31:0] o_addr, o_wd;
    logic [3:0]  o_be;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] d);
        if (k == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic idle_reqs();
        set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic model_reset();
        q.delete();
        favour   = 0;
        m_err    = 1'b0;
        m_errsrc = 1'b0;
    endtask

    // One clock: check every output against the model, then advance the model.
    task automatic step();
        bit    v0, v1, mv, gnt, deq;
        int    win, n;
        logic [1:0]  op;
        logic [31:0] a, d;
        beat_t b;
        #1;
        o_r0 = bus.req0_ready;  o_r1 = bus.req1_ready;  o_mv = bus.mem_valid;
        o_addr = bus.mem_addr;  o_be = bus.mem_byteen;  o_wd = bus.mem_wdata;
        o_err = bus.err_align;  o_src = bus.err_src;    o_busy = bus.busy;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        mv  = (q.size() != 0);
        win = (v0 && v1) ? favour : (v1 ? 1 : 0);
        gnt = (v0 || v1) && (q.size() < DEPTH);
        check("req0_ready", o_r0, gnt && win == 0);
        check("req1_ready", o_r1, gnt && win == 1);
        check("mem_valid",  o_mv, mv);
        check("mem_addr",   o_addr, mv ? q[0].a  : 32'h0);
        check("mem_byteen", o_be,   mv ? q[0].be : 4'h0);
        check("mem_wdata",  o_wd,   mv ? q[0].d  : 32'h0);
        check("busy",       o_busy, mv);
        check("err_align",  o_err, m_err);
        check("err_src",    o_src, m_errsrc);
        deq = mv && bus.mem_ready;
        op  = win ? bus.req1_op    : bus.req0_op;
        a   = win ? bus.req1_addr  : bus.req0_addr;
        d   = win ? bus.req1_wdata : bus.req0_wdata;
        @(posedge clk);
        if (deq) void'(q.pop_front());
        m_err = 1'b0;
        if (gnt) begin
            favour = 1 - win;
            b.a = a & 32'hFFFF_FFFC;
            n   = int'(a % 4);
            case (op)
                2'b01: begin
                    if (n != 0) begin m_err = 1'b1; m_errsrc = win[0]; end
                    else begin b.be = 4'hF; b.d = d; q.push_back(b); end
                end
                2'b10: begin
                    if (n % 2 != 0) begin m_err = 1'b1; m_errsrc = win[0]; end
                    else begin
                        b.be = 4'(3 << n);
                        b.d  = (d & 32'hFFFF) << (8 * n);
                        q.push_back(b);
                    end
                end
                2'b11: begin
                    b.be = 4'(1 << n);
                    b.d  = (d & 32'hFF) << (8 * n);
                    q.push_back(b);
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int k;
        idle_reqs();
        bus.mem_ready = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 20) begin step(); k++; end
        check("drain_done", q.size(), 0);
        step();
    endtask

    initial begin
        idle_reqs();
        bus.mem_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_busy",      bus.busy, 1'b0);
        check("rst_err_align", bus.err_align, 1'b0);
        check("rst_err_src",   bus.err_src, 1'b0);
        check("rst_byteen",    bus.mem_byteen, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin from reset with both requesters always valid.
        bus.mem_ready = 1'b1;
        set_req(0, 1'b1, 2'b01, 32'h0000_0010, 32'hA0A0_A0A0);
        set_req(1, 1'b1, 2'b01, 32'h0000_0020, 32'hB1B1_B1B1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant1", o_r1, i % 2);
            check("rr_grant0", o_r0, (i + 1) % 2);
        end
        drain();

        // Byte store into lane 2.
        set_req(0, 1'b1, 2'b11, 32'h0000_1002, 32'h0000_00AB);
        step();
        check("sb_ready", o_r0, 1'b1);
        idle_reqs();
        step();
        check("sb_valid", o_mv, 1'b1);
        check("sb_addr",  o_addr, 32'h0000_1000);
        check("sb_be",    o_be, 4'b0100);
        check("sb_wdata", o_wd, 32'h00AB_0000);
        drain();

        // Fill with memory stalled; fifth store refused, even on a dequeue cycle.
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1'b1, 2'b01, 32'h0000_4000 + 32'(4 * i), 32'hC000_0000 + 32'(i));
            step();
            check("fill_ready", o_r0, i < 4);
        end
        bus.mem_ready = 1'b1;
        step();
        check("full_deq_ready", o_r0, 1'b0);
        step();
        check("fifth_accept", o_r0, 1'b1);
        drain();

        // Misaligned word from requester 1.
        set_req(1, 1'b1, 2'b01, 32'h0000_2001, 32'hDEAD_BEEF);
        step();
        check("mis_ready", o_r1, 1'b1);
        idle_reqs();
        step();
        check("mis_pulse", o_err, 1'b1);
        check("mis_src",   o_src, 1'b1);
        check("mis_noenq", o_mv, 1'b0);
        step();
        check("mis_pulse_end", o_err, 1'b0);

        // Upper half store with enqueue and dequeue in the same cycle at count 2.
        bus.mem_ready = 1'b0;
        set_req(0, 1'b1, 2'b01, 32'h0000_3100, 32'h1111_1111); step();
        set_req(0, 1'b1, 2'b01, 32'h0000_3104, 32'h2222_2222); step();
        bus.mem_ready = 1'b1;
        set_req(0, 1'b1, 2'b10, 32'h0000_3002, 32'h1234_BEEF); step();
        idle_reqs();
        bus.mem_ready = 1'b0;
        step();
        check("sim_count_busy", q.size(), 2);
        bus.mem_ready = 1'b1;
        step(); step();
        check("sh_be",    o_be, 4'b1100);
        check("sh_wdata", o_wd, 32'hBEEF_0000);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++)
                set_req(k, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        $urandom, $urandom);
            bus.mem_ready = ($urandom_range(0, 9) < 5);
            step();
        end
        drain();

        // Asynchronous reset in the middle of a stalled beat.
        bus.mem_ready = 1'b0;
        set_req(0, 1'b1, 2'b01, 32'h0000_5000, 32'h5555_5555); step();
        set_req(1, 1'b1, 2'b11, 32'h0000_5003, 32'h0000_0077); step();
        idle_reqs();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_valid", bus.mem_valid, 1'b0);
        check("arst_busy",      bus.busy, 1'b0);
        check("arst_byteen",    bus.mem_byteen, 4'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) step();
        set_req(0, 1'b1, 2'b01, 32'h0000_6000, 32'h6666_6666);
        set_req(1, 1'b1, 2'b01, 32'h0000_7000, 32'h7777_7777);
        step();
        check("post_rst_rr", o_r0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_wr_sched.md
MEM_WR_SCHED -- requirements
Module: mem_wr_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of queued store entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports reqK_valid  input  1  store request from requester K (K=0,1).
REQ-005 SHALL have ports reqK_ready  output  1  request K accepted this cycle (valid&&ready).
REQ-006 SHALL have ports reqK_addr  input  32  byte address of requester K.
REQ-007 SHALL have ports reqK_wdata  input  32  store data, right-aligned.
REQ-008 SHALL have ports reqK_op  input  2  store size: 00 none, 01 word, 10 half, 11 byte.
REQ-009 SHALL have port mem_valid  output  1  write beat presented to memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts beat (mem_valid&&mem_ready).
REQ-011 SHALL have port mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-012 SHALL have port mem_byteen  output  4  byte-lane write enables.
REQ-013 SHALL have port mem_wdata  output  32  lane-shifted store data, unused lanes zero.
REQ-014 SHALL have port err_align  output  1  one-cycle pulse on a dropped misaligned request.
REQ-015 SHALL have port err_src  output  1  requester index of the last err_align pulse.
REQ-016 SHALL have port busy  output  1  high when FIFO non-empty.

Function
REQ-017 SHALL grant at most one request per cycle, round-robin; sole valid requester wins; after granting K the pointer favours the other requester.
REQ-018 SHALL assert reqK_ready only for the granted requester and only when FIFO count < FIFO_DEPTH; arbitration pointer unchanged on cycles with no grant.
REQ-019 SHALL accept op=00 requests (ready high) and discard them without enqueue or error.
REQ-020 SHALL treat word with addr[1:0]!=0 and half with addr[0]=1 as misaligned: accept, discard, pulse err_align next cycle, set err_src.
REQ-021 SHALL enqueue aligned stores at the accepting edge with pre-computed byteen/wdata: word 1111/data; half addr[1]=0 -> 0011,{16'b0,d[15:0]}; addr[1]=1 -> 1100,{d[15:0],16'b0}; byte addr[1:0]=n -> one-hot bit n, d[7:0] placed in lane n, other lanes zero.
REQ-022 SHALL use FSM IDLE (FIFO empty, mem_valid=0) and ISSUE (mem_valid=1 presenting FIFO head); IDLE->ISSUE on enqueue; ISSUE->IDLE on handshake leaving FIFO empty; otherwise stay ISSUE.
REQ-023 SHALL hold mem_addr/byteen/wdata stable while mem_valid=1 and mem_ready=0.
REQ-024 SHALL have latency: request accepted at edge N into empty FIFO -> mem_valid=1 in cycle after edge N; back-to-back handshakes retire one entry per cycle.
REQ-025 SHALL handle simultaneous enqueue and dequeue: count unchanged, order preserved (strict FIFO, pointers wrap modulo FIFO_DEPTH).
REQ-026 SHALL not accept when full, even if a dequeue occurs the same cycle.
REQ-027 SHALL drive mem_byteen=0000 and mem_wdata=0 whenever mem_valid=0.

Reset
REQ-028 SHALL on rst_n=0, immediately and regardless of clk: empty FIFO, state IDLE, pointer favours requester 0, all outputs 0; an in-flight beat is abandoned.
REQ-029 SHALL resume normal arbitration on the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL verify: req0 sb addr=0x1002 data=0x000000AB, mem_ready=1 -> mem_valid next cycle, addr 0x1000, byteen 0100, wdata 0x00AB0000.
REQ-031 SHALL verify: both requesters valid 4 cycles, FIFO never full -> grants 0,1,0,1.
REQ-032 SHALL verify: mem_ready=0, 5 word stores -> 4 accepted, 5th ready=0; release mem_ready -> 4 beats in order, then 5th accepted.
REQ-033 SHALL verify: req1 sw addr=0x2001 -> ready=1, no enqueue, err_align pulses 1 cycle, err_src=1.
REQ-034 SHALL verify: sh addr=0x3002 data=0x1234BEEF -> byteen 1100, wdata 0xBEEF0000; simultaneous enq/deq at count 2 keeps count 2.
REQ-035 SHALL verify: rst_n low mid-ISSUE with mem_ready=0 -> mem_valid=0, busy=0 same cycle; no stale beat after release.
